// File: rtl/addsub_seq_ctrl.sv
// Nibble-serial two's-complement adder/subtractor: one 4-bit slice reused
// LSB-first over NIBBLES cycles, with a one-cycle done pulse at the end.
module addsub_seq_ctrl #(
    parameter  int NIBBLES = 4,
    localparam int W       = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result,
    output logic         carry_out,
    output logic         overflow
);
    localparam int            IW   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] idx;
    logic          cy;
    logic [W-1:0]  a_q, b_q;
    logic          op_q;
    logic [3:0]    nib_a, nib_b;
    logic [4:0]    sum;
    logic [3:0]    low;
    logic          accept, last;

    // Subtract is a + ~b + 1: the +1 comes from the carry register seeded with op.
    always_comb begin
        nib_a = a_q[4*idx +: 4];
        nib_b = b_q[4*idx +: 4] ^ {4{op_q}};
        sum   = {1'b0, nib_a} + {1'b0, nib_b} + {4'b0, cy};
        low   = {1'b0, nib_a[2:0]} + {1'b0, nib_b[2:0]} + {3'b0, cy};
    end

    assign last   = (idx == LAST);
    assign accept = start && (state == IDLE || state == DONE);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: if (start) state_nx = CALC;
            CALC: begin
                busy = 1'b1;
                if (last) state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = start ? CALC : IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx       <= '0;
            cy        <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
        end else if (accept) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= op;
            cy   <= op;
            idx  <= '0;
        end else if (state == CALC) begin
            result[4*idx +: 4] <= sum[3:0];
            cy                 <= sum[4];
            idx                <= last ? '0 : idx + 1'b1;
            if (last) begin
                carry_out <= sum[4];
                // carry into bit W-1 vs carry out of it
                overflow  <= low[3] ^ sum[4];
            end
        end
    end
endmodule

// File: tb/tb_addsub_seq_ctrl.sv
// Bench for addsub_seq_ctrl: fixed vectors plus random traffic against an
// arithmetic reference model checked every cycle.
module tb_addsub_seq_ctrl;
    localparam int N = 4;
    localparam int W = 4 * N;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         op = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, carry_out, overflow;
    logic [W-1:0] result;

    addsub_seq_ctrl #(.NIBBLES(N)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result),
        .carry_out(carry_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain integer arithmetic, packed as {overflow, carry, result}.
    function automatic logic [W+1:0] ref_op(input logic o, input logic [W-1:0] x, input logic [W-1:0] y);
        int ux, uy, ur, sx, sy, sr;
        logic co, ov;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        ur = o ? ux - uy : ux + uy;
        sr = o ? sx - sy : sx + sy;
        co = o ? (ux >= uy) : (ur >= (1 << W));
        ov = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
        return {ov, co, W'(ur)};
    endfunction

    // Model: an accepted op stays outstanding N cycles, then publishes for one done cycle.
    int           left = 0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_res = '0;
    logic         m_co = 1'b0, m_ov = 1'b0;
    logic [W+1:0] pend = '0;

    always @(posedge clk) begin
        if (rst) begin
            left   <= 0;
            m_done <= 1'b0;
            m_res  <= '0;
            m_co   <= 1'b0;
            m_ov   <= 1'b0;
        end else if (left > 0) begin
            left   <= left - 1;
            m_done <= (left == 1);
            if (left == 1) begin
                m_res <= pend[W-1:0];
                m_co  <= pend[W];
                m_ov  <= pend[W+1];
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
                left <= N;
                pend <= ref_op(op, a, b);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", 32'(busy), 32'(left > 0));
            chk("done", 32'(done), 32'(m_done));
            if (left == 0) begin
                chk("result", 32'(result), 32'(m_res));
                chk("carry_out", 32'(carry_out), 32'(m_co));
                chk("overflow", 32'(overflow), 32'(m_ov));
            end
        end
    end

    // Wait for done; cyc counts negedges from the call, bcnt counts busy samples.
    task automatic wait_done(input bit drop, output int cyc, output int bcnt);
        cyc  = 0;
        bcnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc++;
            if (drop) start = 1'b0;
            if (busy) bcnt++;
            if (done) return;
        end
        chk("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic run_op(input string name, input logic o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] er, input logic eco, input logic eov);
        int cyc, bc;
        op = o; a = x; b = y; start = 1'b1;
        wait_done(1'b1, cyc, bc);
        chk({name, "_lat"}, 32'(cyc), 32'(N + 1));
        chk({name, "_busycyc"}, 32'(bc), 32'(N));
        chk({name, "_res"}, 32'(result), 32'(er));
        chk({name, "_co"}, 32'(carry_out), 32'(eco));
        chk({name, "_ov"}, 32'(overflow), 32'(eov));
    endtask

    initial begin
        int cyc, bc, dcnt;
        logic [W-1:0] corner [4];
        corner[0] = 16'h0000; corner[1] = 16'h7FFF; corner[2] = 16'h8000; corner[3] = 16'hFFFF;

        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_co", 32'(carry_out), 32'd0);
        chk("rst_ov", 32'(overflow), 32'd0);
        rst = 1'b0;

        // first edge out of reset accepts start
        run_op("add1", 1'b0, 16'h1234, 16'h0FFF, 16'h2233, 1'b0, 1'b0);
        run_op("add2", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b0);
        run_op("add3", 1'b0, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b1);
        run_op("sub1", 1'b1, 16'h8000, 16'h0001, 16'h7FFF, 1'b1, 1'b1);
        run_op("sub2", 1'b1, 16'h0001, 16'h0002, 16'hFFFF, 1'b0, 1'b0);

        // start held through CALC with changing operands
        @(negedge clk);
        op = 1'b0; a = 16'h1111; b = 16'h2222; start = 1'b1;
        @(negedge clk);
        op = 1'b1; a = 16'h0100; b = 16'h0005;
        wait_done(1'b0, cyc, bc);
        chk("hold_first_res", 32'(result), 32'h3333);
        chk("hold_first_lat", 32'(cyc), 32'(N));
        wait_done(1'b1, cyc, bc);
        chk("hold_second_res", 32'(result), 32'h00FB);
        chk("hold_second_gap", 32'(cyc), 32'(N + 1));

        // back-to-back through the DONE cycle
        @(negedge clk);
        op = 1'b0; a = 16'h0001; b = 16'h0001; start = 1'b1;
        wait_done(1'b1, cyc, bc);
        chk("b2b_first_res", 32'(result), 32'h0002);
        a = 16'h0002; b = 16'h0003; start = 1'b1;
        wait_done(1'b1, cyc, bc);
        chk("b2b_gap", 32'(cyc), 32'(N + 1));
        chk("b2b_second_res", 32'(result), 32'h0005);

        // reset in the second CALC cycle aborts with no done
        @(negedge clk);
        op = 1'b0; a = 16'h1234; b = 16'h0001; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_result", 32'(result), 32'd0);
        chk("abort_co", 32'(carry_out), 32'd0);
        rst = 1'b0;
        dcnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) dcnt++;
        end
        chk("abort_no_done", 32'(dcnt), 32'd0);
        run_op("post_abort", 1'b0, 16'h00FF, 16'h0001, 16'h0100, 1'b0, 1'b0);

        // random traffic, operands and start toggled freely, occasional reset
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            rst   = ($urandom_range(0, 79) == 0);
            start = ($urandom_range(0, 2) == 0);
            op    = 1'($urandom);
            a     = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
            b     = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 3)] : W'($urandom);
        end
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        repeat (N + 3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
